// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read / one-write register file.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;

  localparam int unsigned RF_N     = 16;
  localparam int unsigned RF_DEPTH = 8;

  typedef logic [RF_N-1:0] rf_word_t;

  // Address width needed to index 'depth' entries (at least 1 bit).
  function automatic int unsigned rf_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_2r1w_word_reg.sv
// Single N-bit storage word with load enable and synchronous active-low reset.
module rf_word_reg
  import regfile_pkg::*;
#(
  parameter int unsigned N = RF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Clear on reset, otherwise capture d when loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: DEPTH words of N bits, two registered read ports with
// same-cycle write bypass, one write port.
// Optional build macro: REGFILE_ZERO_REG_EN -- register 0 reads as zero,
// writes to it are dropped and bypass to it is suppressed.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned N     = RF_N,
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned AW    = rf_addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_enable,
  input  logic [AW-1:0] write_addr,
  input  logic [N-1:0]  write_data,
  input  logic          read_enable_a,
  input  logic [AW-1:0] read_addr_a,
  output logic [N-1:0]  read_data_a,
  output logic          read_valid_a,
  input  logic          read_enable_b,
  input  logic [AW-1:0] read_addr_b,
  output logic [N-1:0]  read_data_b,
  output logic          read_valid_b
);

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rd_a_c;
  logic [N-1:0] rd_b_c;
  logic         byp_a_c;
  logic         byp_b_c;

  // Storage words; word 0 becomes a constant zero when the zero register is enabled.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign mem_q[g] = '0;
    end else begin : g_reg
      logic load_c;
      assign load_c = write_enable && (write_addr == AW'(g));
      rf_word_reg #(.N(N)) u_word (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .d    (write_data),
        .q    (mem_q[g])
      );
    end
  end

  // Read muxes with write-to-read bypass on address match.
  always_comb begin
    byp_a_c = 1'b0;
    byp_b_c = 1'b0;
    rd_a_c  = mem_q[read_addr_a];
    rd_b_c  = mem_q[read_addr_b];
    if (write_enable && (write_addr == read_addr_a) &&
        !(ZERO_REG && (read_addr_a == '0))) begin
      byp_a_c = 1'b1;
    end
    if (write_enable && (write_addr == read_addr_b) &&
        !(ZERO_REG && (read_addr_b == '0))) begin
      byp_b_c = 1'b1;
    end
    if (byp_a_c) rd_a_c = write_data;
    if (byp_b_c) rd_b_c = write_data;
  end

  // Port A output register: capture on request, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data_a  <= '0;
      read_valid_a <= 1'b0;
    end else begin
      read_valid_a <= read_enable_a;
      if (read_enable_a) read_data_a <= rd_a_c;
    end
  end

  // Port B output register: capture on request, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data_b  <= '0;
      read_valid_b <= 1'b0;
    end else begin
      read_valid_b <= read_enable_b;
      if (read_enable_b) read_data_b <= rd_b_c;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized and directed bench for regfile_2r1w against an array-based model.
module tb_regfile_2r1w;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [N-1:0]  write_data;
  logic          read_enable_a;
  logic [AW-1:0] read_addr_a;
  logic [N-1:0]  read_data_a;
  logic          read_valid_a;
  logic          read_enable_b;
  logic [AW-1:0] read_addr_b;
  logic [N-1:0]  read_data_b;
  logic          read_valid_b;

  int total = 0;
  int bad   = 0;

  // Reference state: register contents and expected port outputs.
  logic [N-1:0] mdl [DEPTH];
  logic [N-1:0] exp_da, exp_db;
  logic         exp_va, exp_vb;

  regfile_2r1w #(.N(N), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_enable  (write_enable),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_enable_a (read_enable_a),
    .read_addr_a   (read_addr_a),
    .read_data_a   (read_data_a),
    .read_valid_a  (read_valid_a),
    .read_enable_b (read_enable_b),
    .read_addr_b   (read_addr_b),
    .read_data_b   (read_data_b),
    .read_valid_b  (read_valid_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value a read of 'addr' observes in a cycle, given that cycle's write.
  function automatic logic [N-1:0] model_read(input logic [AW-1:0] addr, input logic we,
                                              input logic [AW-1:0] wa, input logic [N-1:0] wd);
    if (ZERO && addr == 0) return '0;
    if (we && wa == addr) return wd;
    return mdl[addr];
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [N-1:0] wd, input logic rea, input logic [AW-1:0] ra,
                      input logic reb, input logic [AW-1:0] rb, input string tag);
    rst = r; write_enable = we; write_addr = wa; write_data = wd;
    read_enable_a = rea; read_addr_a = ra; read_enable_b = reb; read_addr_b = rb;
    if (!r) begin
      for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
      exp_da = '0; exp_db = '0; exp_va = 1'b0; exp_vb = 1'b0;
    end else begin
      exp_va = rea;
      exp_vb = reb;
      if (rea) exp_da = model_read(ra, we, wa, wd);
      if (reb) exp_db = model_read(rb, we, wa, wd);
      if (we && !(ZERO && wa == 0)) mdl[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_da"}, 32'(read_data_a), 32'(exp_da));
    check_eq({tag, "_va"}, 32'(read_valid_a), 32'(exp_va));
    check_eq({tag, "_db"}, 32'(read_data_b), 32'(exp_db));
    check_eq({tag, "_vb"}, 32'(read_valid_b), 32'(exp_vb));
  endtask

  initial begin
    // Reset held for two cycles.
    step(1'b0, 1'b1, 3'd2, 16'h1234, 1'b1, 3'd2, 1'b1, 3'd2, "rst0");
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0, "rst1");
    check_eq("rst_data_const", 32'(read_data_a), 32'h0);

    // All addresses read zero after reset.
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, AW'(i), 1'b1, AW'(7 - i), "rd_zero");

    // Write then read, port B idle.
    step(1'b1, 1'b1, 3'd3, 16'hA5A5, 1'b0, 3'd0, 1'b0, 3'd0, "wr3");
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0, "rd3");
    check_eq("rd3_const", 32'(read_data_a), 32'hA5A5);

    // Bypass on both ports.
    step(1'b1, 1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0, "wr5");
    step(1'b1, 1'b1, 3'd5, 16'h2222, 1'b1, 3'd5, 1'b1, 3'd5, "byp5");
    check_eq("byp5_const_b", 32'(read_data_b), 32'h2222);

    // Hold after the request is withdrawn.
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0, "hold_rd");
    step(1'b1, 1'b1, 3'd3, 16'h0F0F, 1'b0, 3'd3, 1'b0, 3'd0, "hold");
    check_eq("hold_const", 32'(read_data_a), 32'hA5A5);

    // Reset in the middle of continuous reads.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd5, "stream");
    step(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 1'b1, 3'd5, "mid_rst");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, AW'(i + 3), 1'b1, 3'd5, "post_rst");

    // Write to address 0 with concurrent read of address 0.
    step(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 3'd0, "zero_byp");
    check_eq("zero_byp_const", 32'(read_data_a), ZERO ? 32'h0 : 32'hFFFF);
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0, "zero_rd");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), AW'($urandom), N'($urandom),
           1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file: N-bit words, DEPTH entries, two independent read ports and one write port.
- Next generation of the single-port lab register file.
- Both reads are registered, with 1-cycle latency and a valid flag per port.
- Same-cycle write-to-read bypass, so it can feed the lab datapath decode stage directly.

Parameters:
N, 16, data word width in bits (>=1)
DEPTH, 8, number of registers (power of two, >=2)
AW, $clog2(DEPTH), address width; derived, do not override

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-low reset; 0 = reset, sampled on posedge clk
write_enable  input  1  write strobe
write_addr  input  AW  write address
write_data  input  N  write data
read_enable_a  input  1  port A read request
read_addr_a  input  AW  port A address
read_data_a  output  N  port A registered read data
read_valid_a  output  1  port A data valid, pulses 1 cycle after request
read_enable_b  input  1  port B read request
read_addr_b  input  AW  port B address
read_data_b  output  N  port B registered read data
read_valid_b  output  1  port B data valid

Behaviour:
- Reset (rst=0 at posedge clk):
  - All DEPTH registers cleared to 0.
  - read_data_a/b = 0; read_valid_a/b = 0.
  - Writes and reads presented in a reset cycle are ignored.
- Write: at posedge with rst=1 and write_enable=1, reg[write_addr] <= write_data. With write_enable=0, storage is unchanged.
- Read, per port independently:
  - At posedge with rst=1 and read_enable_x=1: read_data_x <= value at read_addr_x; read_valid_x <= 1.
  - Latency is exactly 1 cycle from request to data/valid.
- Read hold: with read_enable_x=0, read_data_x holds its last value and read_valid_x <= 0.
- Bypass: if write_enable=1 and write_addr==read_addr_x in the same cycle, read_data_x <= write_data (new value, not stale).
- Both ports may read the same address in the same cycle, with or without a concurrent write; both get identical data.
- Back-to-back reads every cycle are supported; read_valid_x stays 1 continuously.
- Reset mid-operation: a request issued in the cycle rst=0 yields no valid in the next cycle. Outputs are 0 the cycle after reset, then resume normally.
- No combinational path from any input to any output. All outputs are register outputs.
- Addresses are full-range by construction; no out-of-range handling is needed.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - reg[0] is hardwired to 0; writes to address 0 are discarded.
  - Reads of address 0 return 0, including when a same-cycle write targets address 0 (bypass suppressed for address 0).
- Undefined:
  - reg[0] is an ordinary register, writable and bypassable like all others.

Decomposition:
- Shared package regfile_pkg:
  - localparam defaults RF_N=16, RF_DEPTH=8.
  - Function for deriving AW.
  - typedef rf_word_t for the N-bit word.
- One natural sub-module: rf_word_reg, a single N-bit register with load enable and sync active-low reset.
  - Instantiated DEPTH times in a generate loop.
  - Read mux, bypass compare and output registers stay in the top module.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then read all 8 addresses on both ports -> every read_data = 0x0000, valid one cycle after each request.
2. Write/read: write 0xA5A5 to addr 3, next cycle read A=3 -> cycle after: read_data_a=0xA5A5, read_valid_a=1; read_valid_b stays 0.
3. Bypass: addr 5 holds 0x1111; same cycle write 0x2222 to addr 5 and read A=5, B=5 -> both ports return 0x2222 next cycle.
4. Hold: read A=3 (0xA5A5), then deassert read_enable_a and write 0x0F0F to addr 3 -> read_data_a stays 0xA5A5, read_valid_a=0.
5. Reset mid-stream: continuous reads on both ports, drop rst for 1 cycle -> next cycle outputs 0 and valids 0; contents all 0 on subsequent reads.
6. REGFILE_ZERO_REG_EN:
   - Defined: write 0xFFFF to addr 0 while reading addr 0 on A -> read_data_a=0x0000, including the bypass cycle.
   - Undefined: same stimulus -> 0xFFFF.
